// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: bundles the FIFO read port, the flush request and the
// packed valid/ready output of fifo_rd_packer.
//   master : packer side  (pops the FIFO, drives the packed output)
//   slave  : environment  (FIFO + downstream consumer)
// Signals:
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid one cycle after an accepted pop
//   fifo_ren    FIFO pop request
//   flush       one-cycle pulse requesting emission of a partial word
//   out_ready   downstream accepts out_data
//   out_valid   out_data/out_count valid
//   out_data    packed word, first-popped word in the low lane
//   out_count   number of valid lanes in out_data
interface fifo_rd_packer_if #(
  parameter int unsigned FIFO_WIDTH = 4,
  parameter int unsigned PACK_N     = 4
);
  localparam int unsigned CW = $clog2(PACK_N + 1);

  logic                         fifo_empty;
  logic [FIFO_WIDTH-1:0]        fifo_dout;
  logic                         fifo_ren;
  logic                         flush;
  logic                         out_ready;
  logic                         out_valid;
  logic [FIFO_WIDTH*PACK_N-1:0] out_data;
  logic [CW-1:0]                out_count;

  modport master (
    input  fifo_empty, fifo_dout, flush, out_ready,
    output fifo_ren, out_valid, out_data, out_count
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, out_ready,
    input  fifo_ren, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side FIFO consumer. Pops FIFO_WIDTH-bit words, packs
// PACK_N consecutive words into one wide word and presents it on a
// valid/ready output. A flush pulse emits a partially filled, zero-padded
// word together with its lane count.
// Ports:
//   clk_r  read-domain clock, all logic on posedge
//   rst    synchronous, active-high reset
//   bus    fifo_rd_packer_if.master (FIFO read port, flush, packed output)
module fifo_rd_packer #(
  parameter int unsigned FIFO_WIDTH = 4,
  parameter int unsigned PACK_N     = 4
) (
  input  logic                     clk_r,
  input  logic                     rst,
  fifo_rd_packer_if.master         bus
);
  localparam int unsigned CW = $clog2(PACK_N + 1);

  typedef enum logic [1:0] {
    FILL,
    DONE,
    FLUSH
  } state_e;

  logic [PACK_N-1:0][FIFO_WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              pend_q;
  logic                              flush_req_q;
  logic                              out_valid_q;
  logic [FIFO_WIDTH*PACK_N-1:0]      out_data_q;
  logic [CW-1:0]                     out_count_q;

  state_e        state;
  logic          can_load;
  logic          load;
  logic [CW-1:0] eff_cnt;
  logic [CW:0]   inflight;
  logic          lookahead;
  logic          ren;

  always_comb begin
    if (cnt_q == CW'(PACK_N)) begin
      state = DONE;
    end else if (flush_req_q) begin
      state = FLUSH;
    end else begin
      state = FILL;
    end
  end

  assign can_load = !out_valid_q || bus.out_ready;
  assign load     = can_load && ((state == DONE) || (state == FLUSH && !pend_q));

  // Pop gating counts lanes as they will stand after this cycle's transfer.
  // The extra lookahead term lets the pop that fills lane 0 of the next word
  // issue while the last lane of the current word is still in flight, as long
  // as that word is certain to transfer on the capture edge. Together these
  // keep pops back-to-back while streaming (one word per PACK_N cycles).
  assign eff_cnt   = load ? '0 : cnt_q;
  assign inflight  = {1'b0, eff_cnt} + (CW+1)'(pend_q);
  assign lookahead = pend_q && (eff_cnt == CW'(PACK_N - 1)) && can_load && !bus.flush;
  assign ren       = !rst && !bus.fifo_empty && !flush_req_q &&
                     ((inflight < (CW+1)'(PACK_N)) || lookahead);

  // A transfer clears asm before any same-cycle capture lands in lane 0.
  always_comb begin
    asm_d = load ? '0 : asm_q;
    cnt_d = eff_cnt;
    if (pend_q) begin
      for (int unsigned i = 0; i < PACK_N; i++) begin
        if (cnt_d == CW'(i)) begin
          asm_d[i] = bus.fifo_dout;
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk_r) begin
    if (rst) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      pend_q <= ren;
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      if (load) begin
        out_data_q  <= asm_q;
        out_count_q <= cnt_q;
        out_valid_q <= 1'b1;
        flush_req_q <= 1'b0;
      end else begin
        if (bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
        if (bus.flush && state == FILL && (cnt_q != '0 || pend_q)) begin
          flush_req_q <= 1'b1;
        end
      end
    end
  end

  assign bus.fifo_ren  = ren;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: self-checking bench for fifo_rd_packer with
// FIFO_WIDTH=4, PACK_N=4. A small FIFO model feeds the DUT; expected packed
// words are queued as stimulus is driven and compared as the DUT emits them.
module tb_fifo_rd_packer;
  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  logic clk_r = 1'b0;
  logic rst;
  always #5 clk_r = ~clk_r;

  fifo_rd_packer_if #(.FIFO_WIDTH(W), .PACK_N(N)) bus ();

  fifo_rd_packer #(.FIFO_WIDTH(W), .PACK_N(N)) dut (
    .clk_r (clk_r),
    .rst   (rst),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // FIFO model: data written by the stimulus, popped here on accepted reads.
  logic [W-1:0] mem    [0:255];
  int unsigned  pop_at [0:255];
  int unsigned  wr_ptr = 0;
  int unsigned  rd_ptr = 0;
  int unsigned  cyc    = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk_r) begin
    cyc <= cyc + 1;
    if (bus.fifo_ren && !bus.fifo_empty) begin
      bus.fifo_dout        <= mem[rd_ptr[7:0]];
      pop_at[rd_ptr[7:0]]  <= cyc;
      rd_ptr               <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  // Scoreboard
  logic [15:0] exp_data [0:63];
  logic [2:0]  exp_cnt  [0:63];
  int unsigned acc_at   [0:63];
  int unsigned exp_wr = 0;
  int unsigned exp_rd = 0;

  task automatic expect_word(input logic [15:0] d, input logic [2:0] c);
    exp_data[exp_wr[5:0]] = d;
    exp_cnt[exp_wr[5:0]]  = c;
    exp_wr = exp_wr + 1;
  endtask

  always @(negedge clk_r) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_rd == exp_wr) begin
        check("unexpected_word", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        check("out_data", {16'd0, bus.out_data}, {16'd0, exp_data[exp_rd[5:0]]});
        check("out_count", {29'd0, bus.out_count}, {29'd0, exp_cnt[exp_rd[5:0]]});
        acc_at[exp_rd[5:0]] = cyc - 1;
        exp_rd = exp_rd + 1;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_r);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && exp_rd != exp_wr; i++) @(posedge clk_r);
    #1;
    check(tag, exp_rd, exp_wr);
  endtask

  int unsigned p0, a0, bad;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    tick(2);
    @(negedge clk_r);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_out_count", {29'd0, bus.out_count}, 32'd0);
    check("rst_fifo_ren", {31'd0, bus.fifo_ren}, 32'd0);
    @(posedge clk_r); #1;
    rst = 1'b0;

    // Reset mid-word: two lanes captured, then discarded by reset.
    push(4'd1); push(4'd2);
    tick(6);
    check("cnt_before_rst", {29'd0, dut.cnt_q}, 32'd2);
    rst = 1'b1;
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    tick(2);
    @(negedge clk_r);
    check("rst_mid_cnt", {29'd0, dut.cnt_q}, 32'd0);
    check("rst_mid_ren", {31'd0, bus.fifo_ren}, 32'd0);
    check("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk_r); #1;
    rst = 1'b0;
    expect_word(16'h4321, 3'd4);
    wait_drain("drain_after_rst", 40);

    // Streaming 1..8 with out_ready=1.
    p0 = rd_ptr; a0 = exp_rd;
    for (int unsigned v = 1; v <= 8; v++) push(4'(v));
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    wait_drain("drain_stream", 60);
    check("first_latency", acc_at[a0[5:0]] - pop_at[p0[7:0]], 32'd5);
    check("stream_spacing", acc_at[a0[5:0]+6'd1] - acc_at[a0[5:0]], 32'd4);
    check("pops_contiguous", pop_at[p0[7:0]+8'd7] - pop_at[p0[7:0]], 32'd7);

    // Backpressure: 1..12 with out_ready=0.
    bus.out_ready = 1'b0;
    a0 = exp_rd;
    for (int unsigned v = 1; v <= 12; v++) push(4'(v));
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    expect_word(16'hCBA9, 3'd4);
    tick(12);
    bad = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk_r);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4321) bad++;
    end
    check("bp_hold_stable", bad, 32'd0);
    check("bp_fifo_level", wr_ptr - rd_ptr, 32'd4);
    check("bp_ren_low", {31'd0, bus.fifo_ren}, 32'd0);
    check("bp_asm_full", {16'd0, dut.asm_q}, 32'h8765);
    @(posedge clk_r); #1;
    bus.out_ready = 1'b1;
    wait_drain("drain_bp", 60);
    check("bp_back_to_back", acc_at[a0[5:0]+6'd1] - acc_at[a0[5:0]], 32'd1);

    // Flush of a partial word, then a flush with nothing buffered.
    push(4'd5); push(4'd6); push(4'd7);
    tick(10);
    check("flush_cnt_before", {29'd0, dut.cnt_q}, 32'd3);
    expect_word(16'h0765, 3'd3);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    wait_drain("drain_flush", 20);
    tick(3);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    check("empty_flush_no_valid", {31'd0, bus.out_valid}, 32'd0);
    tick(6);
    check("empty_flush_no_word", exp_rd, exp_wr);

    // Flush while a pop of 9 is in flight.
    push(4'd9);
    tick(1);
    check("inflight_pend", {31'd0, dut.pend_q}, 32'd1);
    expect_word(16'h0009, 3'd1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    push(4'd10);
    @(negedge clk_r);
    check("no_pop_while_flush", {31'd0, bus.fifo_ren}, 32'd0);
    wait_drain("drain_inflight_flush", 20);
    push(4'd11); push(4'd12); push(4'd13);
    expect_word(16'hDCBA, 3'd4);
    wait_drain("drain_after_flush", 40);

    // Empty gap in the middle of a word.
    push(4'd1); push(4'd2);
    bad = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk_r);
      if (bus.out_valid !== 1'b0) bad++;
    end
    check("gap_no_valid", bad, 32'd0);
    @(posedge clk_r); #1;
    push(4'd3); push(4'd4);
    expect_word(16'h4321, 3'd4);
    wait_drain("drain_gap", 40);

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
